button_event: RTL

//  Classifies the clean level from the debouncer into single-cycle events:

---
 rtl/button_event.sv | 120 ++++++++++++
 1 files changed

// File: rtl/button_event.sv
// Turns the debounced button level into one-cycle click, double-click,
// long-press and auto-repeat pulses, timed by a local 1 ms tick.
module button_event #(
  parameter int sim     = 0,
  parameter int LONG_MS = 1000,
  parameter int DBL_MS  = 300,
  parameter int RPT_MS  = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic       click,
  output logic       dbl_click,
  output logic       long_press,
  output logic       rpt,        // auto-repeat pulse ("repeat" is reserved in SV)
  output logic [7:0] event_cnt
);

  localparam logic [16:0] DIV_LAST = (sim != 0) ? 17'd31 : 17'd99999;
  localparam logic [10:0] LONG_T   = 11'(LONG_MS);
  localparam logic [10:0] DBL_T    = 11'(DBL_MS);
  localparam logic [10:0] RPT_T    = 11'(RPT_MS);
  localparam logic [10:0] MS_MAX   = 11'h7ff;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PRESS1 = 3'd1;
  localparam logic [2:0] WAIT2  = 3'd2;
  localparam logic [2:0] PRESS2 = 3'd3;
  localparam logic [2:0] LONG   = 3'd4;

  logic [16:0] presc;
  logic        tick;
  logic        in_q, in_qq;
  logic        rise, fall;
  logic [2:0]  state, state_nxt;
  logic [10:0] ms_cnt;
  logic        click_nxt, dbl_nxt, long_nxt, rpt_nxt, restart;
  logic [7:0]  cnt_inc;

  assign tick = (presc == DIV_LAST);
  assign rise = in_q & ~in_qq;
  assign fall = ~in_q & in_qq;

  // Edges take priority over timer expiry in every state.
  always_comb begin
    state_nxt = state;
    click_nxt = 1'b0;
    dbl_nxt   = 1'b0;
    long_nxt  = 1'b0;
    rpt_nxt   = 1'b0;
    restart   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (fall) state_nxt = WAIT2;
        else if (ms_cnt == LONG_T) begin
          state_nxt = LONG;
          long_nxt  = 1'b1;
        end
      end
      WAIT2: begin
        if (rise) state_nxt = PRESS2;
        else if (ms_cnt == DBL_T) begin
          state_nxt = IDLE;
          click_nxt = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_nxt = IDLE;
          dbl_nxt   = 1'b1;
        end else if (ms_cnt == LONG_T) begin
          state_nxt = LONG;
          click_nxt = 1'b1;
          long_nxt  = 1'b1;
        end
      end
      LONG: begin
        if (fall) state_nxt = IDLE;
        else if (ms_cnt == RPT_T) begin
          rpt_nxt = 1'b1;
          restart = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    cnt_inc = {7'd0, click_nxt} + {7'd0, dbl_nxt} + {7'd0, long_nxt};
  end

  // Input history resets high so a button held through reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc      <= '0;
      in_q       <= 1'b1;
      in_qq      <= 1'b1;
      state      <= IDLE;
      ms_cnt     <= '0;
      click      <= 1'b0;
      dbl_click  <= 1'b0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
      event_cnt  <= '0;
    end else begin
      presc      <= tick ? 17'd0 : presc + 17'd1;
      in_q       <= in;
      in_qq      <= in_q;
      state      <= state_nxt;
      if ((state_nxt != state) || restart) ms_cnt <= '0;
      else if (tick && (ms_cnt != MS_MAX)) ms_cnt <= ms_cnt + 11'd1;
      click      <= click_nxt;
      dbl_click  <= dbl_nxt;
      long_press <= long_nxt;
      rpt        <= rpt_nxt;
      event_cnt  <= event_cnt + cnt_inc;
    end
  end

endmodule
